// File: rtl/prach_hb2_pack.sv
// prach_hb2_pack: pairs consecutive TDM samples per channel into
// (older, newer) I/Q pairs for the prach_hb2 half-band decimator.
//
// Ports:
//   clk, rst_n        - clock, async active-low reset
//   din_dq[1:0][15:0] - input sample, [0]=I, [1]=Q
//   din_dv, din_chn   - input valid strobe and TDM channel index
//   sync_in           - frame alignment pulse, clears all pending halves
//   dout_dp1/dout_dp2 - older/newer sample of the emitted pair
//   dout_dv, dout_chn - pair valid strobe and its channel index
//   sync_out          - sync_in delayed one cycle
//   err_chn           - pulse for a valid sample on an unsupported channel
module prach_hb2_pack #(
    parameter int NUM_CHN = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0][15:0] din_dq,
    input  logic             din_dv,
    input  logic [7:0]       din_chn,
    input  logic             sync_in,
    output logic [1:0][15:0] dout_dp1,
    output logic [1:0][15:0] dout_dp2,
    output logic             dout_dv,
    output logic [7:0]       dout_chn,
    output logic             sync_out,
    output logic             err_chn
);

    localparam int IW = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1;
    localparam logic [8:0] NCH = 9'(NUM_CHN);

    logic [NUM_CHN-1:0] ph;
    logic [NUM_CHN-1:0] ph_eff;
    logic [1:0][15:0]   mem [NUM_CHN];

    logic [IW-1:0] idx;
    logic          in_range;
    logic          hit;
    logic          cur_ph;

    // sync_in clears phases before the same-cycle sample is looked at,
    // so that sample always lands as the first half of its channel.
    always_comb begin
        idx      = din_chn[IW-1:0];
        in_range = ({1'b0, din_chn} < NCH);
        hit      = din_dv & in_range;
        ph_eff   = sync_in ? '0 : ph;
        cur_ph   = in_range ? ph_eff[idx] : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph       <= '0;
            dout_dp1 <= '0;
            dout_dp2 <= '0;
            dout_dv  <= 1'b0;
            dout_chn <= '0;
            sync_out <= 1'b0;
            err_chn  <= 1'b0;
        end else begin
            ph <= ph_eff;
            if (hit)
                ph[idx] <= ~cur_ph;
            dout_dv  <= hit & cur_ph;
            if (hit && cur_ph) begin
                dout_dp1 <= mem[idx];
                dout_dp2 <= din_dq;
                dout_chn <= din_chn;
            end
            sync_out <= sync_in;
            err_chn  <= din_dv & ~in_range;
        end
    end

    // Sample store is never read before being written (phase gates it),
    // so it carries no reset.
    always_ff @(posedge clk) begin
        if (hit && !cur_ph)
            mem[idx] <= din_dq;
    end

endmodule

// File: doc/prach_hb2_pack.md
PRACH_HB2_PACK -- requirements
Module: prach_hb2_pack

Interface
REQ-001 Parameter NUM_CHN, default 16, number of TDM channels supported, legal range 1..256.
REQ-002 clk  input  1  sole clock; all logic rising-edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 din_dq  input  2x16  sample I ([0]) and Q ([1]), two's complement.
REQ-005 din_dv  input  1  din_dq/din_chn valid strobe.
REQ-006 din_chn  input  8  TDM channel index of current sample.
REQ-007 sync_in  input  1  single-cycle frame alignment pulse.
REQ-008 dout_dp1  output  2x16  older sample of pair, I/Q, feeds prach_hb2 din_dp1.
REQ-009 dout_dp2  output  2x16  newer sample of pair, I/Q, feeds prach_hb2 din_dp2.
REQ-010 dout_dv  output  1  pair valid strobe.
REQ-011 dout_chn  output  8  channel index of emitted pair.
REQ-012 sync_out  output  1  sync_in delayed to match data latency.
REQ-013 err_chn  output  1  one-cycle pulse: valid sample with din_chn >= NUM_CHN.

Function
REQ-014 Block shall hold per-channel phase bit ph[c] and per-channel sample store mem[c] (2x16).
REQ-015 Valid sample, din_chn=c < NUM_CHN, ph[c]=0: store din_dq into mem[c], set ph[c]=1, no output strobe.
REQ-016 Valid sample, ph[c]=1: next cycle dout_dp1=mem[c], dout_dp2=din_dq, dout_chn=c, dout_dv=1; clear ph[c].
REQ-017 Latency din_dv (second sample) to dout_dv shall be exactly 1 cycle; all outputs registered.
REQ-018 dout_dv shall be 0 in every cycle not produced by REQ-016; dout_dp1/dp2/chn hold last value when dout_dv=0.
REQ-019 Channels are independent; arbitrary interleave of channel indices, including back-to-back same channel, shall pair correctly.
REQ-020 din_dv=1 every cycle shall be sustained with no throughput loss; no backpressure exists.
REQ-021 din_chn >= NUM_CHN with din_dv=1: sample dropped, no state change, err_chn=1 next cycle.
REQ-022 sync_in=1: all ph[] cleared before processing same-cycle sample, so that sample is phase 0 of its channel.
REQ-023 sync_in during pending ph[c]=1: stored half-pair discarded, never emitted.
REQ-024 sync_out = sync_in delayed 1 cycle, independent of din_dv.
REQ-025 din_dv=0 cycles: no state change except sync_in per REQ-022.
REQ-026 Data values pass unmodified; no arithmetic, rounding or saturation.

Reset
REQ-027 rst_n=0: dout_dv=0, sync_out=0, err_chn=0, dout_dp1/dp2=0, dout_chn=0, all ph[]=0, asynchronously.
REQ-028 mem[] contents need no reset; ph[]=0 guarantees they are never read before being written.
REQ-029 Reset mid-pair: half-pair discarded; first valid sample after release is phase 0.

Verification
REQ-030 Ch0 samples (1,2)->(3,4) consecutive: one cycle after second, dout_dp1=(1,2), dout_dp2=(3,4), dout_chn=0, dout_dv=1 for one cycle.
REQ-031 Interleave ch0,ch1,ch0,ch1 values 10,20,11,21 (I=Q): pairs ch0 (10,11) then ch1 (20,21), consecutive dout_dv cycles.
REQ-032 ch3 sample 5, sync_in with ch3 sample 6, then ch3 sample 7: single pair (6,7); 5 never emitted; sync_out one cycle after sync_in.
REQ-033 NUM_CHN=16, din_chn=16 valid: err_chn pulses once, dout_dv stays 0, ph[] unchanged (following ch0 pairing unaffected).
REQ-034 Continuous din_dv=1 across all 16 channels, 2 rounds: 16 pairs, correct dp1/dp2 order, zero gaps beyond pairing pattern.
REQ-035 rst_n low between halves of ch2 pair: outputs zero during reset; after release ch2 samples A,B yield pair (A,B).
